// File: rtl/and_gate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_sequencer
//  Description : Self-test controller for the on-chip 2-input AND gate.
//                A rising edge on start sweeps the gate inputs through all
//                four combinations. Each vector is held for SETTLE_CYCLES
//                before gate_c is compared with the expected truth table.
//                Results are reported as busy / done / pass / err_cnt.
//                Optional feature macro: AND_SEQ_INPUT_SYNC_EN adds a
//                2-flop synchronizer on start and gate_c.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_gate_sequencer #(
    parameter int SETTLE_CYCLES = 4       // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_c,
    output logic       gate_a,
    output logic       gate_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         c_CNT_W       = 8;
    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] c_LAST_VEC    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic                 w_start;
    logic                 w_gate_c;
    logic                 r_start_d;
    logic                 w_start_edge;
    logic                 w_expected;
    logic                 w_mismatch;

    logic [c_CNT_W-1:0]   r_settle_cnt;
    logic [1:0]           r_vec_idx;
    logic [2:0]           r_err_cnt;
    logic                 r_gate_a;
    logic                 r_gate_b;
    logic                 r_busy;
    logic                 r_done;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef AND_SEQ_INPUT_SYNC_EN
    logic [1:0] r_start_sync;
    logic [1:0] r_gate_c_sync;

    // Two-flop synchronizers for the asynchronous start and gate_c pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync  <= 2'b00;
            r_gate_c_sync <= 2'b00;
        end else begin
            r_start_sync  <= {r_start_sync[0], start};
            r_gate_c_sync <= {r_gate_c_sync[0], gate_c};
        end
    end

    assign w_start  = r_start_sync[1];
    assign w_gate_c = r_gate_c_sync[1];
`else
    assign w_start  = start;
    assign w_gate_c = gate_c;
`endif

    // Previous start level, used to turn a held request into a single edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= w_start;
        end
    end

    assign w_start_edge = w_start & ~r_start_d;

    // Truth table of a 2-input AND for the vector under test
    assign w_expected = r_vec_idx[1] & r_vec_idx[0];
    assign w_mismatch = (w_gate_c != w_expected);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start edges outside IDLE/DONE are dropped
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_vec_idx == c_LAST_VEC) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_APPLY;
                end
            end
            S_DONE: begin
                if (w_start_edge) begin
                    w_state_next = S_APPLY;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: vector index, settle timer, error count and status flags
    // ------------------------------------------------------------------
    // All outputs are registered here so the gate inputs never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_vec_idx    <= 2'd0;
            r_err_cnt    <= 3'd0;
            r_gate_a     <= 1'b0;
            r_gate_b     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A new sweep discards the previous results
                    if (w_start_edge) begin
                        r_vec_idx <= 2'd0;
                        r_err_cnt <= 3'd0;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_gate_a     <= r_vec_idx[1];
                    r_gate_b     <= r_vec_idx[0];
                    r_settle_cnt <= c_SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    // At most four increments per sweep, so 3 bits never wrap
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (r_vec_idx == c_LAST_VEC) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_gate_a <= 1'b0;
                        r_gate_b <= 1'b0;
                    end else begin
                        r_vec_idx <= r_vec_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gate_a  = r_gate_a;
    assign gate_b  = r_gate_b;
    assign vec_idx = r_vec_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = r_err_cnt;
    assign pass    = r_done & (r_err_cnt == 3'd0);

endmodule
`default_nettype wire
